// File: rtl/fi_pkg.sv
// Shared types and default bounds for the formal memory responder.
// Request entries, response FSM states and the counter width live here.
package fi_pkg;

    localparam int FI_DEF_DEPTH         = 4;
    localparam int FI_DEF_MAX_GNT_STALL = 3;
    localparam int FI_DEF_MAX_RSP_STALL = 3;
    localparam int FI_DEF_ALLOW_ERROR   = 0;
    localparam int FI_CNT_W             = 5;

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
    } fi_req_t;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } fi_rsp_state_t;

endpackage

// File: rtl/fi_req_fifo.sv
// Small synchronous FIFO of accepted requests; head is read combinationally
// so the responder can see the head entry's type on the response edge.
module fi_req_fifo
    import fi_pkg::*;
#(
    parameter int DEPTH = FI_DEF_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  fi_req_t                  push_data,
    input  logic                     pop,
    output fi_req_t                  head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    fi_req_t        mem_reg [DEPTH];
    logic [AW:0]    wr_ptr_reg;
    logic [AW:0]    rd_ptr_reg;

    // Pointers carry one extra MSB so full and empty are distinguishable.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign count = wr_ptr_reg - rd_ptr_reg;
    assign head  = mem_reg[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push && !full) begin
            mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/fi_mem_responder.sv
// Nondeterministic memory responder for one core port: solver-driven grants
// and responses, bounded so that req/gnt/recv/ack traffic is always fair.
module fi_mem_responder
    import fi_pkg::*;
#(
    parameter int DEPTH         = FI_DEF_DEPTH,
    parameter int MAX_GNT_STALL = FI_DEF_MAX_GNT_STALL,
    parameter int MAX_RSP_STALL = FI_DEF_MAX_RSP_STALL,
    parameter int ALLOW_ERROR   = FI_DEF_ALLOW_ERROR
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     mem_req,
    output logic                     mem_gnt,
    input  logic                     mem_wen,
    input  logic [31:0]              mem_addr,
    output logic                     mem_recv,
    input  logic                     mem_ack,
    output logic                     mem_error,
    output logic [31:0]              mem_rdata,
    input  logic                     nd_gnt,
    input  logic                     nd_rsp,
    input  logic [31:0]              nd_rdata,
    input  logic                     nd_error,
    output logic [$clog2(DEPTH):0]   outstanding
);

    fi_req_t                push_data;
    fi_req_t                head;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;
    logic                   push;
    logic                   pop;
    logic                   gnt_force;
    logic                   rsp_force;
    logic                   go_resp;

    fi_rsp_state_t          state_reg, state_next;
    logic [FI_CNT_W-1:0]    gnt_stall_reg, gnt_stall_next;
    logic [FI_CNT_W-1:0]    rsp_wait_reg, rsp_wait_next;
    logic                   recv_reg, recv_next;
    logic                   error_reg, error_next;
    logic [31:0]            rdata_reg, rdata_next;

    assign push_data = '{wen: mem_wen, addr: mem_addr};

    fi_req_fifo #(
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign gnt_force = (gnt_stall_reg == FI_CNT_W'(MAX_GNT_STALL - 1));
    assign rsp_force = (rsp_wait_reg == FI_CNT_W'(MAX_RSP_STALL - 1));
    assign mem_gnt   = mem_req && !full && (nd_gnt || gnt_force);
    assign push      = mem_gnt;
    // recv only rises with an entry present, so a pop never hits an empty FIFO.
    assign pop       = recv_reg && mem_ack;
    assign go_resp   = !empty && (nd_rsp || rsp_force);

    always_comb begin
        gnt_stall_next = gnt_stall_reg;
        if (mem_gnt) begin
            gnt_stall_next = '0;
        end else if (mem_req && !full) begin
            gnt_stall_next = gnt_stall_reg + 1'b1;
        end
    end

    always_comb begin
        state_next    = state_reg;
        rsp_wait_next = rsp_wait_reg;
        recv_next     = recv_reg;
        error_next    = error_reg;
        rdata_next    = rdata_reg;
        case (state_reg)
            IDLE: begin
                if (go_resp) begin
                    state_next    = RESP;
                    rsp_wait_next = '0;
                    recv_next     = 1'b1;
                    rdata_next    = head.wen ? 32'h0 : nd_rdata;
                    error_next    = (ALLOW_ERROR != 0) && nd_error;
                end else if (empty) begin
                    rsp_wait_next = '0;
                end else begin
                    rsp_wait_next = rsp_wait_reg + 1'b1;
                end
            end
            RESP: begin
                // Response payload is frozen until the core takes it.
                if (mem_ack) begin
                    state_next = IDLE;
                    recv_next  = 1'b0;
                    error_next = 1'b0;
                    rdata_next = 32'h0;
                end
            end
            default: begin
                state_next = IDLE;
                recv_next  = 1'b0;
                error_next = 1'b0;
                rdata_next = 32'h0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            gnt_stall_reg <= '0;
            rsp_wait_reg  <= '0;
            recv_reg      <= 1'b0;
            error_reg     <= 1'b0;
            rdata_reg     <= 32'h0;
        end else begin
            state_reg     <= state_next;
            gnt_stall_reg <= gnt_stall_next;
            rsp_wait_reg  <= rsp_wait_next;
            recv_reg      <= recv_next;
            error_reg     <= error_next;
            rdata_reg     <= rdata_next;
        end
    end

    assign mem_recv    = recv_reg;
    assign mem_error   = error_reg;
    assign mem_rdata   = rdata_reg;
    assign outstanding = count;

endmodule
